// File: rtl/reaction_trial_ctrl.sv
// Reaction-time trial controller: foreperiod, stimulus lamp, ms timing.
// Optional RANDOM_DELAY_EN adds an LFSR-randomised foreperiod.
module reaction_trial_ctrl #(
    parameter int CLK_PER_MS   = 50000,
    parameter int DELAY_MIN_MS = 1000,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_sustain,
    input  logic        react_sustain,
    output logic        debounce_clr,
    output logic        led,
    output logic        busy,
    output logic        result_valid,
    output logic [13:0] result_ms,
    output logic        false_start,
    output logic        timeout
);

    localparam int PS_W = $clog2(CLK_PER_MS);
`ifdef RANDOM_DELAY_EN
    localparam int FP_MAX = DELAY_MIN_MS + 4 * 255;
`else
    localparam int FP_MAX = DELAY_MIN_MS;
`endif
    localparam int FP_W = $clog2(FP_MAX + 2) + 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_MS - 1);
    localparam logic [13:0]     TO_LAST = 14'(TIMEOUT_MS - 1);
    localparam logic [13:0]     TO_VAL  = 14'(TIMEOUT_MS);
    localparam logic [FP_W-1:0] FP_BASE = FP_W'(DELAY_MIN_MS);
    localparam logic [FP_W-1:0] FP_ONE  = FP_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLR0,
        DELAY,
        STIM,
        REPORT,
        CLR1
    } state_t;

    state_t          state;
    logic [PS_W-1:0] presc;
    logic [FP_W-1:0] fp_cnt;
    logic [FP_W-1:0] fp_load;
    logic [13:0]     ms_cnt;
    logic            tick;

    // A ms tick is the last cycle of each prescaler period.
    assign tick = (presc == PS_LAST);

`ifdef RANDOM_DELAY_EN
    logic [7:0] lfsr;

    // Free-running Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign fp_load = FP_BASE + FP_W'({lfsr, 2'b00});
`else
    assign fp_load = FP_BASE;
`endif

    // Trial sequencer; prescaler restarts on every state change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            presc        <= '0;
            fp_cnt       <= '0;
            ms_cnt       <= '0;
            debounce_clr <= 1'b0;
            led          <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_ms    <= '0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            debounce_clr <= 1'b0;
            presc        <= '0;
            case (state)
                IDLE: begin
                    if (start_sustain) begin
                        state        <= CLR0;
                        debounce_clr <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                CLR0: begin
                    fp_cnt <= fp_load;
                    ms_cnt <= '0;
                    state  <= DELAY;
                end
                DELAY: begin
                    if (react_sustain) begin
                        state        <= REPORT;
                        result_valid <= 1'b1;
                        result_ms    <= '0;
                        false_start  <= 1'b1;
                        timeout      <= 1'b0;
                    end else if (tick && (fp_cnt <= FP_ONE)) begin
                        state  <= STIM;
                        led    <= 1'b1;
                        fp_cnt <= '0;
                    end else begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            fp_cnt <= fp_cnt - 1'b1;
                        end
                    end
                end
                STIM: begin
                    if (tick && (ms_cnt >= TO_LAST)) begin
                        state        <= REPORT;
                        led          <= 1'b0;
                        ms_cnt       <= TO_VAL;
                        result_valid <= 1'b1;
                        result_ms    <= TO_VAL;
                        false_start  <= 1'b0;
                        timeout      <= 1'b1;
                    end else if (react_sustain) begin
                        state        <= REPORT;
                        led          <= 1'b0;
                        result_valid <= 1'b1;
                        result_ms    <= ms_cnt;
                        false_start  <= 1'b0;
                        timeout      <= 1'b0;
                    end else begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            ms_cnt <= ms_cnt + 14'd1;
                        end
                    end
                end
                REPORT: begin
                    state        <= CLR1;
                    debounce_clr <= 1'b1;
                end
                CLR1: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    led   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_trial_ctrl.sv
// Self-checking bench for reaction_trial_ctrl (CLK_PER_MS=4,
// DELAY_MIN_MS=3, TIMEOUT_MS=20); optional RANDOM_DELAY_EN trials.
module tb_reaction_trial_ctrl;

    localparam int CPM  = 4;
    localparam int DMIN = 3;
    localparam int TO   = 20;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_sustain = 1'b0;
    logic        react_sustain = 1'b0;
    logic        debounce_clr;
    logic        led;
    logic        busy;
    logic        result_valid;
    logic [13:0] result_ms;
    logic        false_start;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    reaction_trial_ctrl #(
        .CLK_PER_MS  (CPM),
        .DELAY_MIN_MS(DMIN),
        .TIMEOUT_MS  (TO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_sustain(start_sustain),
        .react_sustain(react_sustain),
        .debounce_clr (debounce_clr),
        .led          (led),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ms    (result_ms),
        .false_start  (false_start),
        .timeout      (timeout)
    );

    // Free-running system clock.
    always #5 clock = ~clock;

`ifdef RANDOM_DELAY_EN
    logic [7:0] m_lfsr;

    // Reference LFSR: seed 8'h01, taps 8,6,5,4, one step per clock.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 8'h01;
        else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full trial; react is raised just after edge r counted from the
    // edge that samples start (r < 0 means no react at all).
    task automatic run_trial(input string tag, input int r);
        int led_n = 0;
        int led_first = -1;
        int clr_n = 0;
        int rv_n = 0;
        int fp;
        int n;
        int l = 0;
        int exp_res = 0;
        int exp_led = 0;
        bit exp_fs = 0;
        bit exp_to = 0;
        bit done = 0;
        logic [13:0] res = '0;
        logic fs = 1'b0;
        logic tmo = 1'b0;
        logic led_at_rv = 1'b0;
        @(posedge clock);
        #1 start_sustain = 1'b1;
        for (int e = 0; e < 5000 && !done; e++) begin
            @(posedge clock);
            #1;
`ifdef RANDOM_DELAY_EN
            if (e == 0) l = int'(m_lfsr);
`endif
            if (led) begin
                if (led_n == 0) led_first = e;
                led_n++;
            end
            if (result_valid) begin
                rv_n++;
                res = result_ms;
                fs = false_start;
                tmo = timeout;
                led_at_rv = led;
            end
            if (debounce_clr) begin
                clr_n++;
                start_sustain = 1'b0;
                react_sustain = 1'b0;
            end
            if (e == r) react_sustain = 1'b1;
            if (e > 0 && !busy) done = 1'b1;
        end
        start_sustain = 1'b0;
        react_sustain = 1'b0;
        fp = (DMIN + 4 * l) * CPM;
        if (r >= 1 && r <= fp) begin
            exp_fs = 1'b1;
        end else begin
            n = (r < 0) ? (1 << 30) : r - 1 - fp;
            if (n <= TO * CPM - 2) begin
                exp_res = n / CPM;
                exp_led = n + 1;
            end else begin
                exp_res = TO;
                exp_to = 1'b1;
                exp_led = TO * CPM;
            end
        end
        chk({tag, ".finished"}, 32'(done), 1);
        chk({tag, ".valid_pulses"}, rv_n, 1);
        chk({tag, ".clr_pulses"}, clr_n, 2);
        chk({tag, ".result_ms"}, 32'(res), exp_res);
        chk({tag, ".false_start"}, 32'(fs), 32'(exp_fs));
        chk({tag, ".timeout"}, 32'(tmo), 32'(exp_to));
        chk({tag, ".led_cycles"}, led_n, exp_led);
        if (exp_led > 0) chk({tag, ".led_rise"}, led_first, 1 + fp);
        chk({tag, ".led_at_valid"}, 32'(led_at_rv), 0);
        chk({tag, ".idle_busy"}, 32'(busy), 0);
        chk({tag, ".held_ms"}, 32'(result_ms), exp_res);
    endtask

    initial begin
        #12;
        chk("rst.led", 32'(led), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.valid", 32'(result_valid), 0);
        chk("rst.clr", 32'(debounce_clr), 0);
        chk("rst.result_ms", 32'(result_ms), 0);
        chk("rst.false_start", 32'(false_start), 0);
        chk("rst.timeout", 32'(timeout), 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        react_sustain = 1'b1;
        repeat (4) @(posedge clock);
        #1 chk("idle_ignores_react", 32'(busy), 0);
        react_sustain = 1'b0;

        run_trial("normal", 1 + DMIN * CPM + 42);
        run_trial("false_start", 5);
        run_trial("tie", DMIN * CPM);
        run_trial("timeout", -1);
        run_trial("last_react", 1 + DMIN * CPM + TO * CPM - 2);
        run_trial("react_ignored", 1 + DMIN * CPM + TO * CPM - 1);
        for (int i = 0; i < 8; i++) begin
            run_trial("rand", int'($urandom_range(1, DMIN * CPM + TO * CPM)));
        end
`ifdef RANDOM_DELAY_EN
        for (int i = 0; i < 3; i++) run_trial("rnd_fp", -1);
`endif
        run_trial("pre_reset", 1 + DMIN * CPM + 42);

        @(posedge clock);
        #1 start_sustain = 1'b1;
        for (int i = 0; i < 5000 && !led; i++) begin
            @(posedge clock);
            #1;
            if (debounce_clr) start_sustain = 1'b0;
        end
        chk("mid.led_on", 32'(led), 1);
        repeat (5) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("mid.led", 32'(led), 0);
        chk("mid.busy", 32'(busy), 0);
        chk("mid.result_ms", 32'(result_ms), 0);
        chk("mid.valid", 32'(result_valid), 0);
        chk("mid.clr", 32'(debounce_clr), 0);
        start_sustain = 1'b0;
        react_sustain = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("post.busy", 32'(busy), 0);
        chk("post.led", 32'(led), 0);
        chk("post.clr", 32'(debounce_clr), 0);
        run_trial("post_reset", 1 + DMIN * CPM + 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reaction_trial_ctrl.md
REACTION_TRIAL_CTRL -- requirements
Module: reaction_trial_ctrl

Interface
REQ-001 Parameter CLK_PER_MS, default 50000, clock cycles per millisecond tick; legal range is 2 or more.
REQ-002 Parameter DELAY_MIN_MS, default 1000, minimum foreperiod in ms from trial start to stimulus.
REQ-003 Parameter TIMEOUT_MS, default 9999, no-response limit in ms; legal range is 1 to 16383.
REQ-004 Port clock, input, 1 bit, single system clock; all logic is rising-edge triggered.
REQ-005 Port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 Port start_sustain, input, 1 bit, debounced start level; once high it stays high until the debouncer is cleared.
REQ-007 Port react_sustain, input, 1 bit, debounced react level; once high it stays high until the debouncer is cleared.
REQ-008 Port debounce_clr, output, 1 bit, one-cycle active-high pulse that clears the upstream debouncer.
REQ-009 Port led, output, 1 bit, stimulus lamp.
REQ-010 Port busy, output, 1 bit, high in every state except IDLE.
REQ-011 Port result_valid, output, 1 bit, one-cycle pulse marking the result outputs valid.
REQ-012 Port result_ms, output, 14 bits, reaction time in ms; held until the next result_valid pulse.
REQ-013 Port false_start, output, 1 bit, high if the latest trial ended in a false start; held with result_ms.
REQ-014 Port timeout, output, 1 bit, high if the latest trial ended in a timeout; held with result_ms.

Function
REQ-015 The FSM SHALL have six states: IDLE, CLR0, DELAY, STIM, REPORT and CLR1, all transitions on rising clock edges.
REQ-016 IDLE SHALL go to CLR0 on the first cycle start_sustain is sampled high; react_sustain is ignored in IDLE.
REQ-017 CLR0 SHALL assert debounce_clr for exactly one cycle, load the foreperiod counter, clear the ms counters, then go to DELAY.
REQ-018 Foreperiod SHALL be DELAY_MIN_MS ms; a ms tick is CLK_PER_MS cycles, counted by a prescaler restarted on every state entry.
REQ-019 In DELAY, react_sustain sampled high SHALL go to REPORT with false_start=1, result_ms=0 and timeout=0.
REQ-020 When react_sustain is sampled high in the same cycle the foreperiod expires, the false start SHALL take priority.
REQ-021 On foreperiod expiry with no react, the FSM SHALL go to STIM, and led SHALL be high for every cycle spent in STIM and low in every other state.
REQ-022 In STIM, the ms counter SHALL increment once per completed tick; with N clock cycles in STIM before react is sampled high, result_ms = floor(N/CLK_PER_MS).
REQ-023 When react_sustain is sampled high in STIM, the FSM SHALL go to REPORT with false_start=0 and timeout=0.
REQ-024 When the ms counter reaches TIMEOUT_MS in STIM, the FSM SHALL go to REPORT with result_ms=TIMEOUT_MS and timeout=1; react in that same cycle SHALL be ignored.
REQ-025 REPORT SHALL update result_ms, false_start and timeout, pulse result_valid for exactly one cycle, then go to CLR1.
REQ-026 CLR1 SHALL pulse debounce_clr for one cycle and return to IDLE; there are exactly 2 debounce_clr pulses per trial.
REQ-027 Counters SHALL never wrap: the ms counter saturates at TIMEOUT_MS, and the foreperiod counter stops at 0.

Reset
REQ-028 While reset_n is low, the block SHALL immediately enter IDLE, regardless of the current state and including mid-trial.
REQ-029 While reset_n is low, led, busy, result_valid, debounce_clr, false_start, timeout and result_ms SHALL all be 0, and all counters SHALL be 0.
REQ-030 After reset_n is released, the first transition SHALL occur no earlier than the first rising clock edge.

Configuration
REQ-031 With RANDOM_DELAY_EN defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL be seeded 8'h01 on reset and step every clock.
REQ-032 With RANDOM_DELAY_EN defined, the foreperiod SHALL be DELAY_MIN_MS + 4*L ms, where L is the LFSR value sampled in CLR0.
REQ-033 Without RANDOM_DELAY_EN, the foreperiod SHALL be exactly DELAY_MIN_MS ms, and no LFSR logic SHALL be present.

Verification (CLK_PER_MS=4, DELAY_MIN_MS=3, TIMEOUT_MS=20, RANDOM_DELAY_EN undefined)
REQ-034 Normal trial: raise start, then raise react 42 cycles after led rises -> result_valid pulse with result_ms=10, false_start=0, timeout=0, and exactly 2 debounce_clr pulses.
REQ-035 False start: raise react 5 cycles into DELAY -> led never rises, and result_valid fires with false_start=1 and result_ms=0.
REQ-036 Timeout: no react after start -> led stays high for 80 cycles, then result_valid with result_ms=20, timeout=1, and led=0.
REQ-037 Tie: react rises in the same cycle the 12-cycle foreperiod expires -> false_start=1 and led stays 0.
REQ-038 Reset mid-STIM: pull reset_n low -> led=0, busy=0 and result_ms=0 at once; after release, the block sits in IDLE until start.
REQ-039 Random delay (RANDOM_DELAY_EN defined): run 3 back-to-back trials -> each foreperiod equals (3+4*L)*4 cycles, with L matching the reference LFSR model.
